// File: rtl/icache_tag_ctrl.sv
// icache_tag_ctrl: tag RAM sequencer/arbiter (clear sweep, invalidate, fill, lookup) for a 128 x 21 instruction-cache tag RAM
//   clk_i, rst_i (async, active-high)
//   lookup_valid_i/lookup_addr_i -> lookup_accept_o; resp_valid_o/resp_hit_o one cycle after accept
//   fill_valid_i/fill_addr_i     -> fill_accept_o (writes {1, addr[31:12]} at addr[11:5])
//   inval_valid_i/inval_addr_i   -> inval_accept_o (clears entry at addr[11:5])
//   flush_i restarts the 128-entry clear sweep; busy_o high while sweeping
//   tag_addr_o/tag_data_o/tag_wr_o drive the RAM, tag_data_i is its registered read data
//   ICACHE_TAG_CTRL_INVAL_EN: enables the per-line invalidate path; otherwise inval is ignored
module icache_tag_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_addr_i,
  output logic        lookup_accept_o,
  output logic        resp_valid_o,
  output logic        resp_hit_o,
  input  logic        fill_valid_i,
  input  logic [31:0] fill_addr_i,
  output logic        fill_accept_o,
  input  logic        inval_valid_i,
  input  logic [31:0] inval_addr_i,
  output logic        inval_accept_o,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [6:0]  tag_addr_o,
  output logic [20:0] tag_data_o,
  output logic        tag_wr_o,
  input  logic [20:0] tag_data_i
);
  typedef enum logic {SWEEP, IDLE} state_t;
  state_t      state;
  logic [6:0]  idx;
  logic [19:0] ptag;
  logic        pend, idle, do_flush, do_inval, do_fill, do_lookup;
  logic        unused_bits;
  assign idle = state == IDLE;
  assign do_flush = idle && flush_i;
`ifdef ICACHE_TAG_CTRL_INVAL_EN
  assign do_inval = idle && !flush_i && inval_valid_i;
  assign unused_bits = ^{lookup_addr_i[4:0], fill_addr_i[4:0], inval_addr_i[31:12], inval_addr_i[4:0]};
`else
  assign do_inval = 1'b0;
  assign unused_bits = ^{inval_valid_i, lookup_addr_i[4:0], fill_addr_i[4:0], inval_addr_i[31:12], inval_addr_i[4:0]};
`endif
  assign do_fill = idle && !flush_i && !do_inval && fill_valid_i;
  assign do_lookup = idle && !flush_i && !do_inval && !fill_valid_i && lookup_valid_i;
  assign lookup_accept_o = do_lookup;
  assign fill_accept_o = do_fill;
  assign inval_accept_o = do_inval;
  assign busy_o = !idle;
  assign tag_wr_o = !idle || do_inval || do_fill;
  assign tag_addr_o = !idle ? idx : do_inval ? inval_addr_i[11:5] : do_fill ? fill_addr_i[11:5] : lookup_addr_i[11:5];
  assign tag_data_o = do_fill ? {1'b1, fill_addr_i[31:12]} : 21'd0;
  // The RAM read is already registered, so the compare resolves in the cycle after accept.
  assign resp_valid_o = pend;
  assign resp_hit_o = pend && tag_data_i[20] && (tag_data_i[19:0] == ptag);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= SWEEP;
      idx   <= '0;
      pend  <= 1'b0;
      ptag  <= '0;
    end else begin
      pend <= do_lookup;
      if (do_lookup) ptag <= lookup_addr_i[31:12];
      if (!idle) begin
        idx <= idx + 7'd1;
        if (idx == 7'd127) state <= IDLE;
      end else if (do_flush) begin
        state <= SWEEP;
        idx   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb_icache_tag_ctrl: directed scoreboard bench for icache_tag_ctrl with a behavioural read-first tag RAM
module tb_icache_tag_ctrl;
  logic        clk = 1'b0, rst;
  logic        lookup_valid, fill_valid, inval_valid, flush;
  logic [31:0] lookup_addr, fill_addr, inval_addr;
  logic        lookup_accept, fill_accept, inval_accept, resp_valid, resp_hit, busy, tag_wr;
  logic [6:0]  tag_addr;
  logic [20:0] tag_wdata, tag_rdata;
  logic [20:0] ram [128];
  int          checks = 0, errors = 0;
  bit          exp_q [$];

  icache_tag_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .lookup_valid_i(lookup_valid), .lookup_addr_i(lookup_addr), .lookup_accept_o(lookup_accept),
    .resp_valid_o(resp_valid), .resp_hit_o(resp_hit),
    .fill_valid_i(fill_valid), .fill_addr_i(fill_addr), .fill_accept_o(fill_accept),
    .inval_valid_i(inval_valid), .inval_addr_i(inval_addr), .inval_accept_o(inval_accept),
    .flush_i(flush), .busy_o(busy),
    .tag_addr_o(tag_addr), .tag_data_o(tag_wdata), .tag_wr_o(tag_wr), .tag_data_i(tag_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 128; i++) ram[i] = {1'b1, 20'(i * 3 + 1)};

  always @(posedge clk) begin
    if (tag_wr) ram[tag_addr] <= tag_wdata;
    tag_rdata <= ram[tag_addr];
  end

  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_spurious: resp_valid=1 hit=%0b, no lookup outstanding", resp_hit);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (resp_hit !== e) begin
          errors++;
          $display("FAIL resp_hit: got %0b expected %0b", resp_hit, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Checks one cycle's combinational outputs, then advances to the next negedge.
  task automatic expect_cyc(input string nm, input logic ela, efa, eia, ewr, input logic [6:0] ea,
                            input logic [20:0] ed, input logic eb);
    #1;
    chk(nm, {lookup_accept, fill_accept, inval_accept, tag_wr, tag_addr, tag_wdata, busy},
            {ela, efa, eia, ewr, ea, ed, eb});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sweep(input string nm, input int n, input int flush_at);
    for (int i = 0; i < n; i++) begin
      flush = (i == flush_at);
      expect_cyc(nm, 1'b0, 1'b0, 1'b0, 1'b1, 7'(i), 21'd0, 1'b1);
    end
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    lookup_valid = 1'b0; fill_valid = 1'b0; inval_valid = 1'b0;
    lookup_addr = '0; fill_addr = '0; inval_addr = '0;
    repeat (3) @(negedge clk);
    #1 chk("reset_resp", {30'd0, resp_valid, resp_hit}, 32'd0);
    expect_cyc("reset_outs", 1'b0, 1'b0, 1'b0, 1'b1, 7'd0, 21'd0, 1'b1);
    lookup_valid = 1'b1; lookup_addr = 32'h0000_1000;
    rst = 1'b0;
    sweep("post_reset_sweep", 128, -1);
    exp_q.push_back(1'b0);
    expect_cyc("first_lookup", 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 21'd0, 1'b0);
    lookup_valid = 1'b0;
    fill_valid = 1'b1; fill_addr = 32'h1234_5020;
    expect_cyc("fill_idx1", 1'b0, 1'b1, 1'b0, 1'b1, 7'd1, 21'h112345, 1'b0);
    fill_valid = 1'b0;
    lookup_valid = 1'b1; lookup_addr = 32'h1234_5024;
    exp_q.push_back(1'b1);
    expect_cyc("lookup_hit", 1'b1, 1'b0, 1'b0, 1'b0, 7'd1, 21'd0, 1'b0);
    lookup_addr = 32'h5432_1020;
    exp_q.push_back(1'b0);
    expect_cyc("lookup_miss", 1'b1, 1'b0, 1'b0, 1'b0, 7'd1, 21'd0, 1'b0);
    lookup_valid = 1'b0;
    expect_cyc("no_action", 1'b0, 1'b0, 1'b0, 1'b0, 7'd1, 21'd0, 1'b0);
    fill_valid = 1'b1; inval_valid = 1'b1; lookup_valid = 1'b1;
    fill_addr = 32'h1234_5020; inval_addr = 32'h1234_5020; lookup_addr = 32'h1234_5020;
`ifdef ICACHE_TAG_CTRL_INVAL_EN
    expect_cyc("prio_inval", 1'b0, 1'b0, 1'b1, 1'b1, 7'd1, 21'd0, 1'b0);
    inval_valid = 1'b0;
`endif
    expect_cyc("prio_fill", 1'b0, 1'b1, 1'b0, 1'b1, 7'd1, 21'h112345, 1'b0);
    fill_valid = 1'b0;
    exp_q.push_back(1'b1);
    expect_cyc("prio_lookup", 1'b1, 1'b0, 1'b0, 1'b0, 7'd1, 21'd0, 1'b0);
    lookup_valid = 1'b0;
    inval_valid = 1'b1; inval_addr = 32'h1234_5020;
`ifdef ICACHE_TAG_CTRL_INVAL_EN
    expect_cyc("inval_alone", 1'b0, 1'b0, 1'b1, 1'b1, 7'd1, 21'd0, 1'b0);
    inval_valid = 1'b0;
    exp_q.push_back(1'b0);
`else
    expect_cyc("inval_ignored", 1'b0, 1'b0, 1'b0, 1'b0, 7'd1, 21'd0, 1'b0);
    inval_valid = 1'b0;
    exp_q.push_back(1'b1);
`endif
    lookup_valid = 1'b1;
    expect_cyc("lookup_after_inval", 1'b1, 1'b0, 1'b0, 1'b0, 7'd1, 21'd0, 1'b0);
    lookup_valid = 1'b0;
    fill_valid = 1'b1; fill_addr = 32'h000A_BFE0;
    expect_cyc("fill_idx127", 1'b0, 1'b1, 1'b0, 1'b1, 7'd127, 21'h1000AB, 1'b0);
    fill_valid = 1'b0;
    lookup_valid = 1'b1; lookup_addr = 32'h000A_BFE4;
    exp_q.push_back(1'b1);
    expect_cyc("lookup_idx127", 1'b1, 1'b0, 1'b0, 1'b0, 7'd127, 21'd0, 1'b0);
    flush = 1'b1; fill_valid = 1'b1; fill_addr = 32'h1234_5020;
    expect_cyc("flush_cycle", 1'b0, 1'b0, 1'b0, 1'b0, 7'd127, 21'd0, 1'b0);
    flush = 1'b0;
    sweep("flush_sweep", 128, 5);
    expect_cyc("post_flush_fill", 1'b0, 1'b1, 1'b0, 1'b1, 7'd1, 21'h112345, 1'b0);
    fill_valid = 1'b0;
    exp_q.push_back(1'b0);
    expect_cyc("post_flush_lookup", 1'b1, 1'b0, 1'b0, 1'b0, 7'd127, 21'd0, 1'b0);
    lookup_valid = 1'b0;
    flush = 1'b1;
    expect_cyc("flush2_cycle", 1'b0, 1'b0, 1'b0, 1'b0, 7'd127, 21'd0, 1'b0);
    flush = 1'b0;
    sweep("pre_reset_sweep", 60, -1);
    #1 chk("sweep_idx60", {25'd0, tag_addr}, 32'd60);
    rst = 1'b1;
    #1 chk("reset_mid_sweep", {24'd0, tag_addr, busy, tag_wr, resp_valid}, {24'd0, 7'd0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; lookup_valid = 1'b1;
    sweep("restart_sweep", 128, -1);
    #1 chk("mid_lookup_accept", {31'd0, lookup_accept}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("mid_lookup_discard", {31'd0, resp_valid}, 32'd0);
    lookup_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sweep("final_sweep", 128, -1);
    expect_cyc("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 7'd127, 21'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
